// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-field width, forward-select codes,
// hazard FSM states and the register-match helper.
package pipe_pkg;

    localparam int REG_W = 5;
    localparam int PC_W  = 7;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // Register 0 is hard-wired, so it never counts as a dependency.
    function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a != {REG_W{1'b0}}) && (a == b);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for performance debug.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt_r;

    // Count up on enable, holding at all-ones.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (en && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign count = cnt_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and mul/div sequencing controller for the 5-stage pipeline.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic [REG_W-1:0] WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic [1:0]       PCSrcD,
    input  logic             md_startE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushE,
    output logic             FlushM,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_count
);

    localparam int             MD_CNT_W = 4;
    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 2);

    md_state_e           state_r, state_nxt_s;
    logic [MD_CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic                mdstall_s, md_last_s;
    logic                lwstall_s, brstall_s;
    logic                redirect_s;

    // ALU operand forwarding, M has priority over W.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (RegWriteM && reg_match(WriteRegM, rsE)) begin
            ForwardAE = FWD_M;
        end else if (RegWriteW && reg_match(WriteRegW, rsE)) begin
            ForwardAE = FWD_W;
        end else begin
            ForwardAE = FWD_RF;
        end
        if (RegWriteM && reg_match(WriteRegM, rtE)) begin
            ForwardBE = FWD_M;
        end else if (RegWriteW && reg_match(WriteRegW, rtE)) begin
            ForwardBE = FWD_W;
        end else begin
            ForwardBE = FWD_RF;
        end
    end

    assign ForwardAD = RegWriteM && reg_match(WriteRegM, rsD);
    assign ForwardBD = RegWriteM && reg_match(WriteRegM, rtD);

    assign lwstall_s = MemtoRegE && RegWriteE &&
                       (reg_match(WriteRegE, rsD) || reg_match(WriteRegE, rtD));
    assign brstall_s = BranchD &&
                       ((RegWriteE && (reg_match(WriteRegE, rsD) || reg_match(WriteRegE, rtD))) ||
                        (MemtoRegM && (reg_match(WriteRegM, rsD) || reg_match(WriteRegM, rtD))));

    // Mul/div sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
            cnt_r   <= {MD_CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Mul/div sequencer next state; the start cycle itself already stalls.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        mdstall_s   = 1'b0;
        md_last_s   = 1'b0;
        case (state_r)
            RUN: begin
                if (md_startE) begin
                    mdstall_s   = 1'b1;
                    cnt_nxt_s   = MD_LOAD;
                    state_nxt_s = MD_BUSY;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MD_BUSY: begin
                if (cnt_r != {MD_CNT_W{1'b0}}) begin
                    mdstall_s = 1'b1;
                    cnt_nxt_s = cnt_r - {{(MD_CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    md_last_s   = 1'b1;
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = RUN;
                cnt_nxt_s   = {MD_CNT_W{1'b0}};
            end
        endcase
    end

    // Pipeline stall/flush controls; reset forces a bubble into E.
    always_comb begin
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        FlushE  = 1'b0;
        FlushM  = 1'b0;
        md_done = 1'b0;
        if (rst) begin
            FlushE = 1'b1;
        end else begin
            StallF  = lwstall_s | brstall_s | mdstall_s;
            StallD  = lwstall_s | brstall_s | mdstall_s;
            StallE  = mdstall_s;
            FlushE  = (lwstall_s | brstall_s) & ~mdstall_s;
            FlushM  = mdstall_s;
            md_done = md_last_s;
        end
    end

    assign redirect_s = (PCSrcD != 2'b00) && !StallD && !rst;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (StallD),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (redirect_s),
        .count (redirect_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MD_LATENCY=4 and a MD_LATENCY=2 instance).
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
    logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD;
    logic [1:0]  PCSrcD;
    logic        md_startE;

    logic        StallF, StallD, StallE, FlushE, FlushM, ForwardAD, ForwardBD, md_done;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] stall_cycles, redirect_count;

    logic        d2_StallF, d2_StallD, d2_StallE, d2_FlushE, d2_FlushM, d2_ForwardAD, d2_ForwardBD, d2_md_done;
    logic [1:0]  d2_ForwardAE, d2_ForwardBE;
    logic [15:0] d2_stall_cycles, d2_redirect_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
        .PCSrcD(PCSrcD), .md_startE(md_startE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .md_done(md_done), .stall_cycles(stall_cycles), .redirect_count(redirect_count)
    );

    hazard_ctrl #(.MD_LATENCY(2), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
        .PCSrcD(PCSrcD), .md_startE(md_startE),
        .StallF(d2_StallF), .StallD(d2_StallD), .StallE(d2_StallE), .FlushE(d2_FlushE), .FlushM(d2_FlushM),
        .ForwardAD(d2_ForwardAD), .ForwardBD(d2_ForwardBD), .ForwardAE(d2_ForwardAE), .ForwardBE(d2_ForwardBE),
        .md_done(d2_md_done), .stall_cycles(d2_stall_cycles), .redirect_count(d2_redirect_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
        WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemtoRegE = 1'b0; MemtoRegM = 1'b0; BranchD = 1'b0;
        PCSrcD = 2'b00; md_startE = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        check_eq("rst_stalld", {31'd0, StallD}, 32'd0);
        check_eq("rst_stalle", {31'd0, StallE}, 32'd0);
        check_eq("rst_flushm", {31'd0, FlushM}, 32'd0);
        check_eq("rst_flushe", {31'd0, FlushE}, 32'd1);
        check_eq("rst_stall_cnt", {16'd0, stall_cycles}, 32'd0);
        check_eq("rst_redir_cnt", {16'd0, redirect_count}, 32'd0);
        next_cycle();
        rst = 1'b0;

        // Forwarding priority and register-zero rule
        RegWriteM = 1'b1; WriteRegM = 5'd8; rsE = 5'd8;
        RegWriteW = 1'b1; WriteRegW = 5'd8;
        #1 check_eq("fwdAE_M", {30'd0, ForwardAE}, 32'd2);
        RegWriteM = 1'b0;
        #1 check_eq("fwdAE_W", {30'd0, ForwardAE}, 32'd1);
        rtE = 5'd8;
        #1 check_eq("fwdBE_W", {30'd0, ForwardBE}, 32'd1);
        RegWriteM = 1'b1; WriteRegM = 5'd0; WriteRegW = 5'd0; rsE = 5'd0;
        #1 check_eq("fwdAE_r0", {30'd0, ForwardAE}, 32'd0);
        WriteRegM = 5'd8; rsD = 5'd8;
        #1 check_eq("fwdAD", {31'd0, ForwardAD}, 32'd1);
        check_eq("fwdBD", {31'd0, ForwardBD}, 32'd0);
        check_eq("fwd_no_stall", {31'd0, StallD}, 32'd0);
        clear_inputs();
        next_cycle();

        // Load-use stall
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd5; rtD = 5'd5;
        #1 check_eq("lw_stallf", {31'd0, StallF}, 32'd1);
        check_eq("lw_stalld", {31'd0, StallD}, 32'd1);
        check_eq("lw_flushe", {31'd0, FlushE}, 32'd1);
        check_eq("lw_stalle", {31'd0, StallE}, 32'd0);
        check_eq("lw_cnt0", {16'd0, stall_cycles}, 32'd0);
        next_cycle();
        WriteRegE = 5'd0;
        #1 check_eq("lw_r0_nostall", {31'd0, StallD}, 32'd0);
        check_eq("lw_cnt1", {16'd0, stall_cycles}, 32'd1);
        clear_inputs();

        // Branch hazard blocks redirect until resolved
        BranchD = 1'b1; rsD = 5'd3; RegWriteE = 1'b1; WriteRegE = 5'd3; PCSrcD = 2'b01;
        #1 check_eq("br_stalld", {31'd0, StallD}, 32'd1);
        check_eq("br_flushe", {31'd0, FlushE}, 32'd1);
        next_cycle();
        check_eq("br_redir_held", {16'd0, redirect_count}, 32'd0);
        check_eq("br_cnt2", {16'd0, stall_cycles}, 32'd2);
        WriteRegE = 5'd0;
        #1 check_eq("br_clear_stalld", {31'd0, StallD}, 32'd0);
        next_cycle();
        check_eq("br_redir_one", {16'd0, redirect_count}, 32'd1);
        clear_inputs();

        // Mul/div sequencing, both latencies
        md_startE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("md4_stalld_%0d", i), {31'd0, StallD}, {31'd0, (i < 3)});
            check_eq($sformatf("md4_stalle_%0d", i), {31'd0, StallE}, {31'd0, (i < 3)});
            check_eq($sformatf("md4_flushm_%0d", i), {31'd0, FlushM}, {31'd0, (i < 3)});
            check_eq($sformatf("md4_flushe_%0d", i), {31'd0, FlushE}, 32'd0);
            check_eq($sformatf("md4_done_%0d", i), {31'd0, md_done}, {31'd0, (i == 3)});
            check_eq($sformatf("md2_stalld_%0d", i), {31'd0, d2_StallD}, {31'd0, (i < 1)});
            check_eq($sformatf("md2_done_%0d", i), {31'd0, d2_md_done}, {31'd0, (i == 1)});
            next_cycle();
            md_startE = 1'b0;
        end
        #1 check_eq("md4_back_run", {31'd0, StallD}, 32'd0);
        check_eq("md4_done_low", {31'd0, md_done}, 32'd0);
        check_eq("md4_cnt5", {16'd0, stall_cycles}, 32'd5);

        // Mul/div start together with load-use, then reset mid-busy
        md_startE = 1'b1; MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd5; rtD = 5'd5;
        #1 check_eq("mdlw_stalld", {31'd0, StallD}, 32'd1);
        check_eq("mdlw_stalle", {31'd0, StallE}, 32'd1);
        check_eq("mdlw_flushe", {31'd0, FlushE}, 32'd0);
        next_cycle();
        clear_inputs();
        #1 check_eq("busy1_stalle", {31'd0, StallE}, 32'd1);
        next_cycle();
        rst = 1'b1;
        #1 check_eq("rstbusy_stalld", {31'd0, StallD}, 32'd0);
        check_eq("rstbusy_flushe", {31'd0, FlushE}, 32'd1);
        check_eq("rstbusy_done", {31'd0, md_done}, 32'd0);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("postrst_stalle_%0d", i), {31'd0, StallE}, 32'd0);
            check_eq($sformatf("postrst_done_%0d", i), {31'd0, md_done}, 32'd0);
            check_eq($sformatf("postrst_flushe_%0d", i), {31'd0, FlushE}, 32'd0);
            next_cycle();
        end
        check_eq("postrst_stall_cnt", {16'd0, stall_cycles}, 32'd0);
        check_eq("postrst_redir_cnt", {16'd0, redirect_count}, 32'd0);

        // Saturation of the stall counter
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd5; rtD = 5'd5;
        repeat (65540) @(posedge clk);
        #1 check_eq("sat_reached", {16'd0, stall_cycles}, 32'h0000FFFF);
        repeat (3) @(posedge clk);
        #1 check_eq("sat_held", {16'd0, stall_cycles}, 32'h0000FFFF);
        check_eq("sat_redir_zero", {16'd0, redirect_count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
